// File: rtl/i2c_prog_pkg.sv
// Shared constants for the I2C program loader: command codes, FSM states, default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_prog_pkg;

  localparam int PROG_ADDR_W = 4;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_HALT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_prog_loader.sv
// Decodes the I2C slave byte stream into program-memory writes and core run/halt control.
// Latency: mem_we one cycle after the data byte strobe; mem_addr increments the cycle after.
// Backpressure: none; the I2C byte rate is far below clk, every strobe is consumed or dropped.
module i2c_prog_loader
  import i2c_prog_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_det,
  input  logic              stop_det,
  input  logic              addr_match,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  state_t state_q;
  state_t state_d;

  // Decoded one-cycle actions produced by the FSM for the datapath registers.
  logic set_run;
  logic clr_run;
  logic set_err;
  logic load_addr;
  logic write_byte;

  // Address byte carries bits above the memory depth.
  logic addr_overflow;
  assign addr_overflow = ((rx_data >> ADDR_W) != '0);

  // Last location written: the following increment wraps to zero.
  logic at_top;
  assign at_top = (mem_addr == '1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and command decode; bus events pre-empt any byte in the same cycle.
  always_comb begin
    state_d    = state_q;
    set_run    = 1'b0;
    clr_run    = 1'b0;
    set_err    = 1'b0;
    load_addr  = 1'b0;
    write_byte = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CMD: begin
          if (rx_valid && addr_match) begin
            case (rx_data)
              CMD_LOAD: begin
                clr_run = 1'b1;
                state_d = ST_ADDR;
              end
              CMD_RUN: begin
                set_run = 1'b1;
                state_d = ST_DRAIN;
              end
              CMD_HALT: begin
                clr_run = 1'b1;
                state_d = ST_DRAIN;
              end
              default: begin
                set_err = 1'b1;
                state_d = ST_DRAIN;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            load_addr = 1'b1;
            set_err   = addr_overflow;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          write_byte = rx_valid;
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Write strobe, data capture and auto-incrementing address after each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= write_byte;
      if (write_byte) begin
        mem_wdata <= rx_data;
      end
      if (load_addr) begin
        mem_addr <= rx_data[ADDR_W-1:0];
      end else if (mem_we) begin
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

  // Core run control; reset leaves the core halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_run <= 1'b0;
    end else if (set_run) begin
      cpu_run <= 1'b1;
    end else if (clr_run) begin
      cpu_run <= 1'b0;
    end
  end

  // Sticky error; an addressed START opens a fresh transaction and clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_det && addr_match) begin
      err <= 1'b0;
    end else if (set_err || (mem_we && at_top)) begin
      err <= 1'b1;
    end
  end

  // Registered busy tracks the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_prog_loader.sv
// Directed bench for i2c_prog_loader: drives byte/event pulses and checks writes and flags.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_i2c_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_det = 1'b0;
  logic       stop_det = 1'b0;
  logic       addr_match = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] wr_addr[$];
  logic [7:0] wr_data[$];

  i2c_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start_det(start_det), .stop_det(stop_det),
    .addr_match(addr_match), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Log every memory write strobe seen away from the rising edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic ev_start(input logic am);
    @(negedge clk);
    start_det  = 1'b1;
    addr_match = am;
    @(negedge clk);
    start_det = 1'b0;
  endtask

  task automatic ev_stop();
    @(negedge clk);
    stop_det = 1'b1;
    @(negedge clk);
    stop_det = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 4'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); else pass_cnt++;
    total_cnt++; if (cpu_run !== 1'b0) $display("FAIL reset_cpu_run got %b want 0", cpu_run); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    clear_log();
    ev_start(1'b1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL load_busy_mid got %b want 1", busy); else pass_cnt++;
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    ev_stop();
    total_cnt++; if (wr_addr.size() !== 2) $display("FAIL load_nwrites got %0d want 2", wr_addr.size());
    else begin
      pass_cnt++;
      total_cnt++; if (wr_addr[0] !== 4'd3 || wr_data[0] !== 8'hAA) $display("FAIL load_wr0 got %0d/%h want 3/aa", wr_addr[0], wr_data[0]); else pass_cnt++;
      total_cnt++; if (wr_addr[1] !== 4'd4 || wr_data[1] !== 8'hBB) $display("FAIL load_wr1 got %0d/%h want 4/bb", wr_addr[1], wr_data[1]); else pass_cnt++;
    end
    total_cnt++; if (mem_addr !== 4'd5) $display("FAIL load_final_addr got %0d want 5", mem_addr); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL load_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (cpu_run !== 1'b0) $display("FAIL load_cpu_run got %b want 0", cpu_run); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL load_busy_end got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_run_halt();
    clear_log();
    ev_start(1'b1);
    send_byte(8'h02);
    ev_stop();
    total_cnt++; if (cpu_run !== 1'b1) $display("FAIL run_cpu_run got %b want 1", cpu_run); else pass_cnt++;
    ev_start(1'b1);
    send_byte(8'h03);
    send_byte(8'h55);
    ev_stop();
    total_cnt++; if (cpu_run !== 1'b0) $display("FAIL halt_cpu_run got %b want 0", cpu_run); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL halt_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (wr_addr.size() !== 0) $display("FAIL halt_nwrites got %0d want 0", wr_addr.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_log();
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h0F);
    send_byte(8'h11);
    send_byte(8'h22);
    ev_stop();
    total_cnt++; if (wr_addr.size() !== 2) $display("FAIL wrap_nwrites got %0d want 2", wr_addr.size());
    else begin
      pass_cnt++;
      total_cnt++; if (wr_addr[0] !== 4'd15 || wr_data[0] !== 8'h11) $display("FAIL wrap_wr0 got %0d/%h want 15/11", wr_addr[0], wr_data[0]); else pass_cnt++;
      total_cnt++; if (wr_addr[1] !== 4'd0 || wr_data[1] !== 8'h22) $display("FAIL wrap_wr1 got %0d/%h want 0/22", wr_addr[1], wr_data[1]); else pass_cnt++;
    end
    total_cnt++; if (err !== 1'b1) $display("FAIL wrap_err got %b want 1", err); else pass_cnt++;
    ev_start(1'b0);
    total_cnt++; if (err !== 1'b1) $display("FAIL wrap_err_unaddressed got %b want 1", err); else pass_cnt++;
    ev_start(1'b1);
    total_cnt++; if (err !== 1'b0) $display("FAIL wrap_err_cleared got %b want 0", err); else pass_cnt++;
    ev_stop();
  endtask

  task automatic test_bad_cmd_addr();
    clear_log();
    ev_start(1'b1);
    send_byte(8'h02);
    ev_stop();
    ev_start(1'b1);
    send_byte(8'h7E);
    ev_stop();
    total_cnt++; if (err !== 1'b1) $display("FAIL badcmd_err got %b want 1", err); else pass_cnt++;
    total_cnt++; if (cpu_run !== 1'b1) $display("FAIL badcmd_cpu_run got %b want 1", cpu_run); else pass_cnt++;
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h23);
    ev_stop();
    total_cnt++; if (mem_addr !== 4'd3) $display("FAIL badaddr_mem_addr got %0d want 3", mem_addr); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL badaddr_err got %b want 1", err); else pass_cnt++;
    total_cnt++; if (wr_addr.size() !== 0) $display("FAIL bad_nwrites got %0d want 0", wr_addr.size()); else pass_cnt++;
    ev_start(1'b1);
    send_byte(8'h02);
    ev_stop();
  endtask

  task automatic test_reset_midload();
    clear_log();
    total_cnt++; if (cpu_run !== 1'b1) $display("FAIL rstmid_pre_cpu_run got %b want 1", cpu_run); else pass_cnt++;
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h05);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    rst      = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rstmid_mem_we got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (cpu_run !== 1'b0) $display("FAIL rstmid_cpu_run got %b want 0", cpu_run); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_addr !== 4'd0) $display("FAIL rstmid_mem_addr got %0d want 0", mem_addr); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (wr_addr.size() !== 0) $display("FAIL rstmid_nwrites got %0d want 0", wr_addr.size()); else pass_cnt++;
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hCC);
    ev_stop();
    total_cnt++; if (wr_addr.size() !== 1) $display("FAIL rstmid_reload_nwrites got %0d want 1", wr_addr.size());
    else begin
      pass_cnt++;
      total_cnt++; if (wr_addr[0] !== 4'd2 || wr_data[0] !== 8'hCC) $display("FAIL rstmid_reload_wr got %0d/%h want 2/cc", wr_addr[0], wr_data[0]); else pass_cnt++;
    end
    total_cnt++; if (err !== 1'b0) $display("FAIL rstmid_reload_err got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_events();
    clear_log();
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'hD1);
    send_byte(8'hD2);
    ev_start(1'b1);
    send_byte(8'h02);
    total_cnt++; if (cpu_run !== 1'b1) $display("FAIL rstart_cpu_run got %b want 1", cpu_run); else pass_cnt++;
    ev_stop();
    total_cnt++; if (wr_addr.size() !== 2) $display("FAIL rstart_nwrites got %0d want 2", wr_addr.size());
    else begin
      pass_cnt++;
      total_cnt++; if (wr_addr[1] !== 4'd5 || wr_data[1] !== 8'hD2) $display("FAIL rstart_wr1 got %0d/%h want 5/d2", wr_addr[1], wr_data[1]); else pass_cnt++;
    end
    ev_start(1'b1);
    @(negedge clk);
    start_det = 1'b1;
    stop_det  = 1'b1;
    @(negedge clk);
    start_det = 1'b0;
    stop_det  = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL stop_start_busy got %b want 0", busy); else pass_cnt++;
    clear_log();
    ev_start(1'b1);
    send_byte(8'h01);
    send_byte(8'h08);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    stop_det = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    stop_det = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (wr_addr.size() !== 0) $display("FAIL stop_byte_nwrites got %0d want 0", wr_addr.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL stop_byte_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_addr !== 4'd8) $display("FAIL stop_byte_mem_addr got %0d want 8", mem_addr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_wrap();
    test_bad_cmd_addr();
    test_reset_midload();
    test_events();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
